// File: rtl/kfpga_config_pkg.sv
// Shared definitions for the logic-tile configuration loader: FSM encoding
// and the default per-tile configuration chain length.
package kfpga_config_pkg;

    localparam int TILE_CHAIN_LENGTH = 146;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

endpackage

// File: rtl/config_loader_if.sv
// Host word handshake plus the serial configuration-chain pins.
// slave is the loader's view; master is the host/chain side.
interface config_loader_if #(
    parameter int WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_valid;
    logic                  word_ready;
    logic                  chain_data;
    logic                  chain_enable;
    logic                  chain_nreset;
    logic                  chain_tail;

    modport slave (
        input  word_data, word_valid, chain_tail,
        output word_ready, chain_data, chain_enable, chain_nreset
    );

    modport master (
        output word_data, word_valid, chain_tail,
        input  word_ready, chain_data, chain_enable, chain_nreset
    );
endinterface

// File: rtl/config_word_serializer.sv
// Buffers host words and emits them LSB first, one bit per cycle, taking
// only as many bits from each word as the chain still needs.
module config_word_serializer #(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_LENGTH = 146
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  active_next,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_data,
    output logic                  chain_enable
);
    localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
    localparam int BUF_W = $clog2(WORD_WIDTH + 1);

    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic [BUF_W-1:0]      buf_cnt_q, buf_cnt_d;
    logic [CNT_W-1:0]      host_need_q, host_need_d;
    logic [CNT_W-1:0]      take_s;
    logic                  accept_s;
    logic                  data_q, data_d;
    logic                  en_q, en_d;
    logic                  word_ready_q, word_ready_d;

    // Buffer, bit-presentation and ready generation for the next cycle.
    always_comb begin
        accept_s    = word_valid && word_ready_q;
        buf_d       = buf_q;
        buf_cnt_d   = buf_cnt_q;
        host_need_d = host_need_q;
        data_d      = 1'b0;
        en_d        = 1'b0;
        if (int'(host_need_q) >= WORD_WIDTH) begin
            take_s = CNT_W'(WORD_WIDTH);
        end else begin
            take_s = host_need_q;
        end
        if (init) begin
            buf_d       = {WORD_WIDTH{1'b0}};
            buf_cnt_d   = {BUF_W{1'b0}};
            host_need_d = CNT_W'(CHAIN_LENGTH);
        end else if (accept_s) begin
            // Bit 0 goes straight out; the rest waits in the buffer.
            data_d      = word_data[0];
            en_d        = 1'b1;
            buf_d       = {1'b0, word_data[WORD_WIDTH-1:1]};
            buf_cnt_d   = BUF_W'(take_s - CNT_W'(1));
            host_need_d = host_need_q - take_s;
        end else if (buf_cnt_q != {BUF_W{1'b0}}) begin
            data_d    = buf_q[0];
            en_d      = 1'b1;
            buf_d     = {1'b0, buf_q[WORD_WIDTH-1:1]};
            buf_cnt_d = buf_cnt_q - BUF_W'(1);
        end else begin
            data_d = 1'b0;
            en_d   = 1'b0;
        end
        word_ready_d = active_next && (buf_cnt_d == {BUF_W{1'b0}})
                       && (host_need_d != {CNT_W{1'b0}});
    end

    // Serializer state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_q        <= {WORD_WIDTH{1'b0}};
            buf_cnt_q    <= {BUF_W{1'b0}};
            host_need_q  <= {CNT_W{1'b0}};
            data_q       <= 1'b0;
            en_q         <= 1'b0;
            word_ready_q <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            buf_cnt_q    <= buf_cnt_d;
            host_need_q  <= host_need_d;
            data_q       <= data_d;
            en_q         <= en_d;
            word_ready_q <= word_ready_d;
        end
    end

    assign word_ready   = word_ready_q;
    assign chain_data   = data_q;
    assign chain_enable = en_q;
endmodule

// File: rtl/config_loader.sv
// Configuration chain loader: clears the chain, streams CHAIN_LENGTH bits
// from host words into it and checks chain integrity via the chain tail.
module config_loader
    import kfpga_config_pkg::*;
#(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_LENGTH = TILE_CHAIN_LENGTH,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    config_loader_if.slave  bus,
    output logic            busy,
    output logic            done,
    output logic            error
);
    localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             nreset_q, nreset_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             first_bit_q, first_bit_d;
    logic             init_s, active_next_s, check_fail_s;
    logic             ser_ready_s, ser_data_s, ser_en_s;

    config_word_serializer #(
        .WORD_WIDTH  (WORD_WIDTH),
        .CHAIN_LENGTH(CHAIN_LENGTH)
    ) u_serializer (
        .clock       (clock),
        .reset       (reset),
        .init        (init_s),
        .active_next (active_next_s),
        .word_data   (bus.word_data),
        .word_valid  (bus.word_valid),
        .word_ready  (ser_ready_s),
        .chain_data  (ser_data_s),
        .chain_enable(ser_en_s)
    );

    // Next-state, counters and integrity checks.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        clr_cnt_d    = clr_cnt_q;
        nreset_d     = 1'b1;
        error_d      = error_q;
        first_bit_d  = first_bit_q;
        init_s       = 1'b0;
        check_fail_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CLEAR;
                    init_s    = 1'b1;
                    error_d   = 1'b0;
                    bit_cnt_d = CNT_W'(CHAIN_LENGTH);
                    clr_cnt_d = CLR_W'(CLEAR_CYCLES);
                    nreset_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q <= CLR_W'(1)) begin
                    state_d = ST_LOAD;
                end else begin
                    clr_cnt_d = clr_cnt_q - CLR_W'(1);
                    nreset_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                // The chain was just cleared, so the tail must read 0 while shifting.
                if (ser_en_s) begin
                    bit_cnt_d   = bit_cnt_q - CNT_W'(1);
                    error_d     = error_q | bus.chain_tail;
                    first_bit_d = (bit_cnt_q == CNT_W'(CHAIN_LENGTH)) ? ser_data_s : first_bit_q;
                    state_d     = (bit_cnt_q == CNT_W'(1)) ? ST_CHECK : ST_LOAD;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_CHECK: begin
                // After exactly CHAIN_LENGTH shifts the first bit sits at the tail.
                check_fail_s = (bus.chain_tail != first_bit_q);
                error_d      = error_q | check_fail_s;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_CHECK);
        active_next_s = (state_d == ST_LOAD);
    end

    // State register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= {CNT_W{1'b0}};
            clr_cnt_q   <= {CLR_W{1'b0}};
            nreset_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            first_bit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            clr_cnt_q   <= clr_cnt_d;
            nreset_q    <= nreset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            first_bit_q <= first_bit_d;
        end
    end

    // The tail comparison resolves during the done cycle itself.
    assign error            = error_q | check_fail_s;
    assign busy             = busy_q;
    assign done             = done_q;
    assign bus.word_ready   = ser_ready_s;
    assign bus.chain_data   = ser_data_s;
    assign bus.chain_enable = ser_en_s;
    assign bus.chain_nreset = nreset_q;
endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: a 146-bit chain model, directed word
// vectors, stalls, stuck tails, mid-load reset and ignored restarts.
module tb_config_loader;
    import kfpga_config_pkg::*;

    localparam int WW = 32;
    localparam int CL = 146;
    localparam int CC = 2;
    localparam int NW = 5;

    typedef struct {
        logic [CL-1:0] img;
        logic          err;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start;
    logic busy, done, error;
    logic [CL-1:0] chain = '0;
    int tail_mode = 0;
    logic [WW-1:0] words [NW+1];

    exp_t sb[$];
    exp_t mon_e;
    int errors = 0, checks = 0, cyc = 0;
    int start_cyc = 0, en_cnt = 0, acc_cnt = 0, late_cnt = 0, done_cnt = 0;

    config_loader_if #(.WORD_WIDTH(WW)) bus ();

    config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL), .CLEAR_CYCLES(CC)) dut (
        .clock(clk), .reset(rst), .start(start), .bus(bus.slave),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: first bit shifted ends at position CL-1, the tail.
    always @(posedge clk) begin
        if (!bus.chain_nreset) chain <= '0;
        else if (bus.chain_enable) chain <= {chain[CL-2:0], bus.chain_data};
    end
    assign bus.chain_tail = (tail_mode == 1) ? 1'b1 : (tail_mode == 2) ? 1'b0 : chain[CL-1];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CL-1:0] img_of();
        logic [CL-1:0] r;
        logic [WW-1:0] w;
        for (int s = 0; s < CL; s++) begin
            w = words[s / WW];
            r[CL-1-s] = w[s % WW];
        end
        return r;
    endfunction

    // Monitor: per-load counters and scoreboard pop on each done pulse.
    always @(negedge clk) begin
        if (start && !busy && !rst) begin
            start_cyc = cyc; en_cnt = 0; acc_cnt = 0; late_cnt = 0;
        end
        if (bus.chain_enable) en_cnt++;
        if (busy && bus.word_ready && acc_cnt >= NW) late_cnt++;
        if (bus.word_valid && bus.word_ready) acc_cnt++;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("chain_image", {14'd0, chain}, {14'd0, mon_e.img});
                chk("error_at_done", {159'd0, error}, {159'd0, mon_e.err});
                chk("enable_count", en_cnt, CL);
                chk("accepted_words", acc_cnt, NW);
                chk("ready_after_last", late_cnt, 0);
                if (mon_e.lat >= 0) chk("start_to_done", cyc - start_cyc, mon_e.lat);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_chain_data"}, {159'd0, bus.chain_data}, 160'd0);
        chk({tag, "_chain_enable"}, {159'd0, bus.chain_enable}, 160'd0);
        chk({tag, "_chain_nreset"}, {159'd0, bus.chain_nreset}, 160'd1);
        chk({tag, "_word_ready"}, {159'd0, bus.word_ready}, 160'd0);
        chk({tag, "_busy"}, {159'd0, busy}, 160'd0);
        chk({tag, "_done"}, {159'd0, done}, 160'd0);
        chk({tag, "_error"}, {159'd0, error}, 160'd0);
    endtask

    task automatic run_load(input bit stall, input bit extra, input bit mid_start,
                            input bit abort, input int exp_lat, input logic exp_err);
        int idx = 0;
        int guard = 0;
        int d0;
        bit pulsed = 1'b0;
        exp_t e;
        if (!abort) begin
            e.img = img_of(); e.err = exp_err; e.lat = exp_lat;
            sb.push_back(e);
        end
        d0 = done_cnt;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        while (guard < 2000 && done_cnt == d0) begin
            if (idx < NW) begin
                bus.word_data  = words[idx];
                bus.word_valid = stall ? ($urandom_range(99) >= 30) : 1'b1;
            end else begin
                bus.word_data  = words[NW];
                bus.word_valid = extra;
            end
            start = mid_start && !pulsed && idx == 2;
            if (start) pulsed = 1'b1;
            @(negedge clk);
            if (bus.word_valid && bus.word_ready && idx < NW) idx++;
            if (abort && en_cnt >= 70) break;
            @(posedge clk); #1;
            guard++;
        end
        bus.word_valid = 1'b0;
        start = 1'b0;
        if (abort) begin
            @(posedge clk); #1; rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs("abort");
            rst = 1'b0;
        end else if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL load_timeout: got no done after %0d cycles expected done", guard);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_load", {159'd0, busy}, 160'd0);
    endtask

    initial begin
        words[0] = 32'h1234_5679; words[1] = 32'hDEAD_BEEF; words[2] = 32'h0F0F_A5A5;
        words[3] = 32'h8000_0001; words[4] = 32'h0003_5A5A; words[5] = 32'hCAFE_F00D;
        rst = 1'b1; start = 1'b0;
        bus.word_valid = 1'b0; bus.word_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1; rst = 1'b0;

        run_load(1'b0, 1'b0, 1'b0, 1'b0, CC + 1 + CL + 1, 1'b0);   // back-to-back
        run_load(1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);                // 30% stalls
        words[4] = 32'hFFFF_FFFF;
        run_load(1'b0, 1'b1, 1'b0, 1'b0, 150, 1'b0);               // excess bits, 6th word offered
        words[4] = 32'h0003_5A5A;
        tail_mode = 1;
        run_load(1'b0, 1'b0, 1'b0, 1'b0, 150, 1'b1);               // tail stuck at 1
        tail_mode = 2;
        run_load(1'b0, 1'b0, 1'b0, 1'b0, 150, 1'b1);               // tail stuck at 0, first bit 1
        tail_mode = 0;
        run_load(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);                 // reset at bit 70
        run_load(1'b0, 1'b0, 1'b0, 1'b0, 150, 1'b0);               // clean reload
        run_load(1'b0, 1'b0, 1'b1, 1'b0, 150, 1'b0);               // start during LOAD

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
